// File: rtl/aes_inv_sbox_seq.sv
// rtl/aes_inv_sbox_seq.sv - iterative AES inverse S-box: inverse affine then x^254 by square-and-multiply
module aes_inv_sbox_seq #(
  parameter logic [7:0] POLY  = 8'h1B,
  parameter logic [7:0] AFF_C = 8'h05
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  localparam logic [7:0] EXP_E = 8'hFE;

  typedef enum logic [1:0] {IDLE, EXP, DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_base, w_base_nxt;
  logic [7:0] r_result, w_result_nxt;
  logic [7:0] r_out, w_out_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] w_invaff, w_sq, w_mul;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // y[i] = s[i+2] ^ s[i+5] ^ s[i+7] (mod 8) expressed as rotations
  assign w_invaff = {in_data[1:0], in_data[7:2]} ^ {in_data[4:0], in_data[7:5]} ^
                    {in_data[6:0], in_data[7]} ^ AFF_C;
  assign w_sq  = gf_mul(r_base, r_base);
  assign w_mul = gf_mul(r_result, r_base);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_base   <= 8'h00;
      r_result <= 8'h01;
      r_out    <= 8'h00;
      r_cnt    <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_base   <= w_base_nxt;
      r_result <= w_result_nxt;
      r_out    <= w_out_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_base_nxt   = r_base;
    w_result_nxt = r_result;
    w_out_nxt    = r_out;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_base_nxt   = w_invaff;
          w_result_nxt = 8'h01;
          w_cnt_nxt    = 3'd0;
          w_state_nxt  = EXP;
        end
      end
      EXP: begin
        // LSB-first exponent walk; the last bit folds straight into the output register
        if (EXP_E[r_cnt]) w_result_nxt = w_mul;
        w_base_nxt = w_sq;
        w_cnt_nxt  = r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          w_out_nxt   = EXP_E[7] ? w_mul : r_result;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_out;

endmodule

// File: tb/tb_aes_inv_sbox_seq.sv
// tb/tb_aes_inv_sbox_seq.sv - directed and exhaustive bench for aes_inv_sbox_seq
module tb_aes_inv_sbox_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;

  int total = 0;
  int bad = 0;
  logic [7:0] sbox [256];

  aes_inv_sbox_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // forward S-box built independently: brute-force inverse then forward affine
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] c;
    inv = 8'h00;
    c = 8'h63;
    for (int y = 1; y < 256; y++) if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return b;
  endfunction

  // called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    check("acc_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    check("busy", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_out(input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check({tag, "_lat"}, 32'(n), 32'd8);
    check(tag, 32'(out_data), 32'(exp));
    check({tag, "_rdy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic take();
    @(negedge clk);
    check("drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) sbox[x] = m_sbox(8'(x));

    repeat (2) @(negedge clk);
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_dat", 32'(out_data), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'h63); wait_out(8'h00, "zero"); take();

    send(8'h7C); wait_out(8'h01, "seq7c"); take();
    send(8'h00); wait_out(8'h52, "seq00"); take();
    send(8'hED); wait_out(8'h53, "seqed"); take();
    send(8'h16); wait_out(8'hFF, "seq16"); take();

    // exhaustive: feeding Sbox(x) must return x for every x
    for (int x = 0; x < 256; x++) begin
      send(sbox[x]);
      wait_out(8'(x), $sformatf("rt%02h", x));
      take();
    end

    // back-pressure
    out_ready = 1'b0;
    send(8'h00);
    wait_out(8'h52, "bp");
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_vld", 32'(out_valid), 32'd1);
      check("bp_dat", 32'(out_data), 32'h52);
      check("bp_rdy", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    take();
    send(8'hAA); wait_out(8'h62, "bp_aa"); take();

    // async reset in the middle of EXP
    send(8'h7C);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_vld", 32'(out_valid), 32'd0);
    check("ar_dat", 32'(out_data), 32'h00);
    check("ar_rdy", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("ar_stale", 32'(out_valid), 32'd0);
    end
    send(8'hED); wait_out(8'h53, "ar_ed"); take();

    // input changes during EXP are ignored; next byte waits for the DONE handshake
    send(8'h16);
    in_valid = 1'b1;
    in_data  = 8'h63;
    wait_out(8'hFF, "chg16");
    @(negedge clk);
    check("chg_drop", 32'(out_valid), 32'd0);
    check("chg_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("chg_acc", 32'(in_ready), 32'd0);
    wait_out(8'h00, "chg63");
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_sbox_seq.md
Name: aes_inv_sbox_seq

Overview:
Iterative AES inverse S-box (InvSubBytes, one byte at a time) and the decrypt-side counterpart of the forward affine stage.
- Applies the inverse affine transformation to the input byte, then computes the GF(2^8) multiplicative inverse as x^254 by square-and-multiply, one exponent bit per cycle.
- Uses valid/ready handshakes on both sides.
- Sits in the decryption datapath, feeding the InvShiftRows/AddRoundKey logic.

Parameters:
POLY, 8'h1B, low byte of the reduction polynomial x^8+x^4+x^3+x+1 (0x11B); used by xtime reduction.
AFF_C, 8'h05, constant XORed after the inverse affine bit-mix.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data valid
in_ready  output  1  unit can accept a byte
in_data  input  8  S-box output byte to invert
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  8  InvSbox(in_data)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; out_data=8'h00.
  - Internal base=0, result=8'h01, bit counter=0.
  - Reset mid-computation discards the byte in flight; no output is produced for it.
- Inverse affine (combinational on in_data, bit i):
  - y[i] = s[(i+2)%8] ^ s[(i+5)%8] ^ s[(i+7)%8] ^ AFF_C[i].
- GF multiply:
  - Combinational 8x8 shift-and-add in GF(2^8).
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? POLY : 0).
  - Two instances: square (base*base) and multiply (result*base).
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, at the clock edge: base<=invaff(in_data), result<=8'h01, cnt<=0, go to EXP.
  - EXP: in_ready=0. Each cycle handles exponent bit k=cnt of E=254=8'b11111110:
    - if E[k]=1, result<=result*base;
    - always base<=base*base;
    - cnt<=cnt+1.
    - When cnt=7, also load out_data<=(E[7] ? result*base : result), i.e. the final product, then go to DONE.
  - DONE: out_valid=1, out_data stable. On out_valid&out_ready go to IDLE and drop out_valid on that edge.
- Latency and throughput:
  - Accept edge = edge 0; out_valid goes high after edge 8 (8 cycles after accept).
  - Minimum 10 cycles per byte: 1 IDLE + 8 EXP + ≥1 DONE.
- Zero input: invaff(0x63)=0x00, and 0^254 evaluates to 0 with no special case (InvSbox(0x63)=0x00).
- Back-pressure: out_data and out_valid hold indefinitely while out_ready=0. in_ready stays 0 throughout EXP and DONE.
- Input rules:
  - in_valid while in_ready=0 is ignored, and in_data need not be held.
  - in_data is sampled only on the accept edge, so changes during EXP have no effect.
- out_ready with out_valid=0 has no effect.
- No combinational path from in_* to out_* or from out_ready to in_ready.

Test Plan:
- Reset then in_data=8'h63 with valid pulse -> out_valid high 8 cycles after accept, out_data=8'h00.
- Sequential bytes 8'h7C, 8'h00, 8'hED, 8'h16 with out_ready=1 -> out_data 8'h01, 8'h52, 8'h53, 8'hFF, each after 8-cycle latency; in_ready low during EXP/DONE.
- Exhaustive 0x00..0xFF against a golden InvSbox table, plus a round-trip check InvSbox(Sbox(x))=x for all x.
- Back-pressure: out_ready=0 for 20 cycles after result 8'h52 -> out_valid and out_data held; in_valid=1 with 8'hAA during that time is not accepted; after out_ready=1, the next accept yields 8'h62 (InvSbox(0xAA)).
- rst_n low at EXP cycle 4 for input 8'h7C -> out_valid=0, out_data=0x00, in_ready=1 immediately (async); no stale output after release; next byte 8'hED -> 8'h53.
- Input changed during EXP (accept 8'h16, then drive 8'h63 with in_valid=1) -> result 8'hFF; 8'h63 accepted only after the DONE handshake, giving 8'h00.
